// File: rtl/ex_issue_stage.sv
// ex_issue_stage: operand/issue register between decode and the ALU.
// A main register drives the ALU-facing outputs and a skid register absorbs
// the one extra operation that can arrive while IN_READY is still high, so
// IN_READY can be a flop and the stage still sustains one op per cycle.
module ex_issue_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int CTRL_WIDTH     = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      FLUSH,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_WIDTH-1:0]     IN_A,
  input  logic [DATA_WIDTH-1:0]     IN_B,
  input  logic [CTRL_WIDTH-1:0]     IN_ALUC,
  input  logic [REG_ADDR_WIDTH-1:0] IN_RD,
  input  logic                      IN_WREG,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [DATA_WIDTH-1:0]     OUT_A,
  output logic [DATA_WIDTH-1:0]     OUT_B,
  output logic [CTRL_WIDTH-1:0]     OUT_ALUC,
  output logic [REG_ADDR_WIDTH-1:0] OUT_RD,
  output logic                      OUT_WREG,
  output logic [1:0]                OCC
);

  // One held operation: {A, B, ALUC, RD, WREG}, WREG in bit 0.
  localparam int ENT_W = 2 * DATA_WIDTH + CTRL_WIDTH + REG_ADDR_WIDTH + 1;

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [ENT_W-1:0] main_q, main_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic [ENT_W-1:0] in_ent;
  logic             in_fire;
  logic             out_fire;
  logic             main_wreg;

  assign in_ent   = {IN_A, IN_B, IN_ALUC, IN_RD, IN_WREG};
  assign in_fire  = IN_VALID & in_ready_q;
  assign out_fire = OUT_VALID & OUT_READY;

  // Next-state and storage update; FLUSH overrides everything except reset.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_ent;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_ent;
        end else if (in_fire) begin
          skid_d  = in_ent;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Wrong-path work: drop both entries and any same-cycle input, but keep
    // the output fields at their last values so the ALU inputs do not toggle.
    if (FLUSH) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != FULL);
  end

  // Control and main register; main is cleared on reset so outputs read zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
    end
  end

  // Skid payload only matters while FULL, so it carries no reset.
  always_ff @(posedge CLK) begin
    skid_q <= skid_d;
  end

  assign {OUT_A, OUT_B, OUT_ALUC, OUT_RD, main_wreg} = main_q;
  assign OUT_VALID = (state_q != EMPTY);
  assign OUT_WREG  = main_wreg & OUT_VALID;
  assign OCC       = state_q;
  assign IN_READY  = in_ready_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Scoreboard bench for ex_issue_stage: accepted operations are queued by a
// reference FIFO model and compared against the DUT outputs every cycle.
module tb_ex_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [4:0]  rd;
    logic        wreg;
  } ent_t;

  logic        CLK;
  logic        RST;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_A;
  logic [31:0] IN_B;
  logic [3:0]  IN_ALUC;
  logic [4:0]  IN_RD;
  logic        IN_WREG;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_A;
  logic [31:0] OUT_B;
  logic [3:0]  OUT_ALUC;
  logic [4:0]  OUT_RD;
  logic        OUT_WREG;
  logic [1:0]  OCC;

  ex_issue_stage #(
    .DATA_WIDTH(32), .CTRL_WIDTH(4), .REG_ADDR_WIDTH(5)
  ) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_A(IN_A), .IN_B(IN_B), .IN_ALUC(IN_ALUC), .IN_RD(IN_RD), .IN_WREG(IN_WREG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_A(OUT_A), .OUT_B(OUT_B), .OUT_ALUC(OUT_ALUC), .OUT_RD(OUT_RD),
    .OUT_WREG(OUT_WREG), .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_errors = 0;
  ent_t sb_q[$];
  ent_t m_last;
  bit   m_known = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT state with the model, then
  // advance the model by what should happen at the coming rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic wr,
                      input logic ordy, input logic fl, input logic rs);
    ent_t e;
    bit   m_vld, m_rdy, in_f, out_f;
    IN_VALID  = v;
    IN_A      = a;
    IN_B      = (a * 32'h9E37_79B9) ^ 32'h0000_1234;
    IN_ALUC   = a[7:4] ^ a[3:0];
    IN_RD     = a[4:0] + 5'd3;
    IN_WREG   = wr;
    OUT_READY = ordy;
    FLUSH     = fl;
    RST       = rs;
    #1;
    m_vld = (sb_q.size() > 0);
    m_rdy = (sb_q.size() < 2);
    if (m_known) begin
      check_eq("occ", OCC, sb_q.size());
      check_eq("out_valid", OUT_VALID, m_vld);
      check_eq("in_ready", IN_READY, m_rdy);
      check_eq("out_wreg", OUT_WREG, m_vld & m_last.wreg);
      check_eq("out_a", OUT_A, m_last.a);
      check_eq("out_b", OUT_B, m_last.b);
      check_eq("out_aluc", OUT_ALUC, m_last.aluc);
      check_eq("out_rd", OUT_RD, m_last.rd);
    end
    e     = '{a: IN_A, b: IN_B, aluc: IN_ALUC, rd: IN_RD, wreg: IN_WREG};
    in_f  = v & m_rdy;
    out_f = m_vld & ordy;
    if (rs) begin
      sb_q.delete();
      m_last  = '0;
      m_known = 1;
    end else begin
      if (out_f) void'(sb_q.pop_front());
      if (fl) sb_q.delete();
      else if (in_f) sb_q.push_back(e);
      if (sb_q.size() > 0) m_last = sb_q[0];
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_A = '0; IN_B = '0; IN_ALUC = '0; IN_RD = '0; IN_WREG = 1'b0;
    m_last = '0;
    @(negedge CLK);

    // Reset held two cycles with offers present; nothing may be captured.
    step(1, 32'h99, 1, 1, 0, 1);
    step(1, 32'h99, 1, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    check_eq("rst_out_a", OUT_A, 32'h0);
    step(0, 0, 0, 1, 0, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) step(1, i, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Backpressure into FULL, refused third offer, then drain in order.
    step(1, 32'h10, 1, 0, 0, 0);
    step(1, 32'h20, 1, 0, 0, 0);
    check_eq("bp_occ_full", OCC, 2'd2);
    check_eq("bp_ready_low", IN_READY, 1'b0);
    step(1, 32'h30, 1, 0, 0, 0);
    step(1, 32'h30, 1, 0, 0, 0);
    check_eq("bp_head_stable", OUT_A, 32'h10);
    step(1, 32'h30, 1, 1, 0, 0);
    step(1, 32'h30, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Flush while FULL with a simultaneous offer.
    step(1, 32'h41, 1, 0, 0, 0);
    step(1, 32'h42, 0, 0, 0, 0);
    step(1, 32'h55, 1, 0, 1, 0);
    check_eq("flush_valid", OUT_VALID, 1'b0);
    check_eq("flush_ready", IN_READY, 1'b1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Reset while FULL.
    step(1, 32'hAA, 1, 0, 0, 0);
    step(1, 32'hBB, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    check_eq("midrst_a", OUT_A, 32'h0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Constant offers with OUT_READY toggling.
    for (int i = 0; i < 12; i++) step(1, 32'h100 + i, i[0], (i % 2) == 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1),
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 79) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
